// File: rtl/writeback_queue.sv
// Write-back queue: circular FIFO of pending register-file writes, drained one per
// cycle through a registered write port, with read-after-write hazard flags.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    InValid,
   output logic                    InReady,
   input  logic [4:0]              InAdd,
   input  logic [31:0]             InData,
   input  logic                    Stall,
   output logic                    EnW,
   output logic [4:0]              WAdd,
   output logic [31:0]             DIn,
   input  logic [4:0]              ReadA,
   input  logic [4:0]              ReadB,
   output logic                    HazA,
   output logic                    HazB,
   output logic [$clog2(DEPTH):0]  Count,
   output logic                    Full,
   output logic                    Empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]       r_add  [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_enw;
   logic [4:0]       r_wadd;
   logic [31:0]      r_din;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_haz_a;
   logic w_haz_b;

   // Pop decision uses the pre-edge count, so a push into an empty queue is never bypassed.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == CW'(0));
   assign w_push  = InValid && !w_full;
   assign w_pop   = !w_empty && !Stall;

   // Queue storage, pointers, occupancy and the registered register-file write port.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_add[i]  <= 5'd0;
            r_data[i] <= 32'd0;
         end
         r_valid <= {DEPTH{1'b0}};
         r_wptr  <= AW'(0);
         r_rptr  <= AW'(0);
         r_count <= CW'(0);
         r_enw   <= 1'b0;
         r_wadd  <= 5'd0;
         r_din   <= 32'd0;
      end else begin
         if (w_pop) begin
            r_enw            <= 1'b1;
            r_wadd           <= r_add[r_rptr];
            r_din            <= r_data[r_rptr];
            r_valid[r_rptr]  <= 1'b0;
            r_rptr           <= r_rptr + AW'(1);
         end else begin
            r_enw <= 1'b0;
         end
         if (w_push) begin
            r_add[r_wptr]   <= InAdd;
            r_data[r_wptr]  <= InData;
            r_valid[r_wptr] <= 1'b1;
            r_wptr          <= r_wptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A read is hazardous while its register is queued or being written this cycle.
   always_comb begin
      w_haz_a = r_enw && (r_wadd == ReadA);
      w_haz_b = r_enw && (r_wadd == ReadB);
      for (int i = 0; i < DEPTH; i++) begin
         w_haz_a = w_haz_a | (r_valid[i] && (r_add[i] == ReadA));
         w_haz_b = w_haz_b | (r_valid[i] && (r_add[i] == ReadB));
      end
   end

   assign InReady = !w_full;
   assign Full    = w_full;
   assign Empty   = w_empty;
   assign Count   = r_count;
   assign EnW     = r_enw;
   assign WAdd    = r_wadd;
   assign DIn     = r_din;
   assign HazA    = w_haz_a;
   assign HazB    = w_haz_b;

endmodule
